// File: rtl/u712_pkg.sv
// Shared U712 arbiter definitions: cycle states, responder indices and the
// pin-drive encoding used by the 68040 termination logic.
`timescale 1ns/1ps
package u712_pkg;

  localparam int unsigned NUM_SRC_DEF = 4;
  localparam int unsigned TIMEOUT_DEF = 255;

  localparam int unsigned SRC_REG  = 0;
  localparam int unsigned SRC_RAM  = 1;
  localparam int unsigned SRC_CHIP = 2;
  localparam int unsigned SRC_PCI  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_TEA,
    ST_TURN
  } ack_state_e;

  typedef struct packed {
    logic ta;
    logic tbi;
    logic tea;
  } pin_drive_t;

  localparam pin_drive_t PINS_HIGH = '{ta: 1'b1, tbi: 1'b1, tea: 1'b1};

  // Active-low pin levels to present while in state s.
  function automatic pin_drive_t pins_for(ack_state_e s, logic burst);
    pin_drive_t p;
    p = PINS_HIGH;
    case (s)
      ST_ACK: begin
        p.ta  = 1'b0;
        p.tbi = burst;
      end
      ST_TEA: begin
        p.tbi = 1'b0;
        p.tea = 1'b0;
      end
      default: p = PINS_HIGH;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/u712_ack_prio_enc.sv
// Lowest-index-wins priority encoder over responder claims, with
// no-claim and multiple-claim flags.
`timescale 1ns/1ps
module u712_ack_prio_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             none,
  output logic             multi
);

  logic [N-1:0] low_cleared;

  always_comb begin
    idx = '0;
    // Scan downward so the last hit is the lowest set index.
    for (int unsigned i = 0; i < N; i++) begin
      if (req[N-1-i]) idx = IDX_W'(N-1-i);
    end
    none        = ~|req;
    low_cleared = req & (req - {{(N-1){1'b0}}, 1'b1});
    multi       = |low_cleared;
  end

endmodule

// File: rtl/u712_cycle_ack_arbiter.sv
// Sole driver of the 68040 nTA/nTBI/nTEA pins: latches the claiming responder
// at nTS, sequences single/burst acks, forces nTEA on timeout.
`timescale 1ns/1ps
module u712_cycle_ack_arbiter
  import u712_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               CLK40,
  input  logic               nRESET,
  input  logic               nTS,
  input  logic               LINE,
  input  logic [NUM_SRC-1:0] SEL,
  input  logic [NUM_SRC-1:0] ACK,
  input  logic [NUM_SRC-1:0] BURST_OK,
  output logic               nTA,
  output logic               nTBI,
  output logic               nTEA,
  output logic [1:0]         OWNER,
  output logic               BUSY,
  output logic               MULTI_ERR
);

  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] TCNT_MAX  = 8'(TIMEOUT);

  ack_state_e state_q, state_d;
  logic [1:0] owner_q;
  logic       burst_q;
  logic       none_q;
  logic [7:0] tcnt_q;
  logic [1:0] beat_q;
  pin_drive_t pins_q;
  logic       oe_q;
  logic       busy_q;
  logic       multi_q;

  logic [1:0] enc_idx;
  logic       enc_none;
  logic       enc_multi;

  u712_ack_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (2)
  ) u_prio (
    .req   (SEL),
    .idx   (enc_idx),
    .none  (enc_none),
    .multi (enc_multi)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!nTS) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!none_q && ACK[owner_q]) state_d = ST_ACK;
        else if (tcnt_q == TCNT_LAST) state_d = ST_TEA;
      end
      ST_ACK:  state_d = (!burst_q || beat_q == 2'd3) ? ST_TURN : ST_WAIT;
      ST_TEA:  state_d = ST_TURN;
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin levels and enable are registered from the next state, so the pins
  // change on the same edge as the state and never see ACK combinationally.
  always_ff @(posedge CLK40 or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      burst_q <= 1'b0;
      none_q  <= 1'b0;
      tcnt_q  <= '0;
      beat_q  <= '0;
      pins_q  <= PINS_HIGH;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pins_q  <= pins_for(state_d, burst_q);
      oe_q    <= (state_d != ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (!nTS) begin
            owner_q <= enc_idx;
            none_q  <= enc_none;
            burst_q <= LINE & BURST_OK[enc_idx] & ~enc_none;
            tcnt_q  <= '0;
            beat_q  <= '0;
            if (enc_multi) multi_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (tcnt_q != TCNT_MAX) tcnt_q <= tcnt_q + 8'd1;
        end
        ST_ACK: begin
          beat_q <= beat_q + 2'd1;
          tcnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign nTA       = oe_q ? pins_q.ta  : 1'bz;
  assign nTBI      = oe_q ? pins_q.tbi : 1'bz;
  assign nTEA      = oe_q ? pins_q.tea : 1'bz;
  assign OWNER     = owner_q;
  assign BUSY      = busy_q;
  assign MULTI_ERR = multi_q;

endmodule

// File: tb/tb_u712_cycle_ack_arbiter.sv
// Bench for u712_cycle_ack_arbiter: per-transaction expected pin timelines
// built from beat gaps, with randomized noise on ignored inputs.
`timescale 1ns/1ps
module tb_u712_cycle_ack_arbiter;

  localparam int TO = 255;

  logic       CLK40    = 1'b0;
  logic       nRESET   = 1'b0;
  logic       nTS      = 1'b1;
  logic       LINE     = 1'b0;
  logic [3:0] SEL      = '0;
  logic [3:0] ACK      = '0;
  logic [3:0] BURST_OK = '0;
  wire        nTA, nTBI, nTEA;
  logic [1:0] OWNER;
  logic       BUSY, MULTI_ERR;

  // Released pins read as 0, the hazardous level for a floating nTA.
  pulldown (nTA);
  pulldown (nTBI);
  pulldown (nTEA);

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  logic multi_exp = 1'b0;

  always #5 CLK40 = ~CLK40;

  u712_cycle_ack_arbiter #(
    .NUM_SRC (4),
    .TIMEOUT (255)
  ) dut (
    .CLK40     (CLK40),
    .nRESET    (nRESET),
    .nTS       (nTS),
    .LINE      (LINE),
    .SEL       (SEL),
    .ACK       (ACK),
    .BURST_OK  (BURST_OK),
    .nTA       (nTA),
    .nTBI      (nTBI),
    .nTEA      (nTEA),
    .OWNER     (OWNER),
    .BUSY      (BUSY),
    .MULTI_ERR (MULTI_ERR)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected entry per cycle: {nTA, nTBI, nTEA, BUSY}, released pins as 0.
  // gN = WAIT cycles until the owner's ACK strobe (strobe in the last one);
  // gN > TO means the beat never gets acked. rst_mode 1: reset in WAIT,
  // 2: reset in the first ACK cycle.
  task automatic txn(input string name, input logic [3:0] sel, input logic line,
                     input logic [3:0] bok, input int g0, input int g1,
                     input int g2, input int g3, input int rst_mode);
    logic [3:0] exp_q[$];
    int         ack_cyc[$];
    int         gaps[4];
    int         owner, nbeats, c, ai, rst_cyc;
    logic       none, burst;
    logic [3:0] noise;
    gaps    = '{g0, g1, g2, g3};
    none    = (sel == 4'b0000);
    owner   = 0;
    for (int i = 3; i >= 0; i--) if (sel[i]) owner = i;
    burst   = !none && line && bok[owner];
    nbeats  = burst ? 4 : 1;
    rst_cyc = (rst_mode == 1) ? 2 : -1;
    exp_q.push_back(4'b0000);
    c = 1;
    for (int k = 0; k < nbeats; k++) begin
      if (none || gaps[k] > TO) begin
        repeat (TO) exp_q.push_back(4'b1111);
        exp_q.push_back(4'b1001);
        break;
      end
      repeat (gaps[k]) exp_q.push_back(4'b1111);
      ack_cyc.push_back(c + gaps[k] - 1);
      if (rst_mode == 2 && k == 0) rst_cyc = c + gaps[k];
      exp_q.push_back({1'b0, burst, 1'b1, 1'b1});
      c += gaps[k] + 1;
    end
    exp_q.push_back(4'b1111);

    ai = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLK40);
      chk({name, "/pins"}, {4'b0, nTA, nTBI, nTEA, BUSY}, {4'b0, exp_q[i]});
      chk({name, "/multi"}, {7'b0, MULTI_ERR}, {7'b0, multi_exp});
      if (exp_q[i][0] && !none) chk({name, "/owner"}, {6'b0, OWNER}, 8'(owner));
      if (i == 0 && $countones(sel) > 1) multi_exp = 1'b1;
      if (i == rst_cyc) begin
        #3 nRESET = 1'b0;
        multi_exp = 1'b0;
        #1;
        chk({name, "/rst_pins"}, {4'b0, nTA, nTBI, nTEA, BUSY}, 8'h00);
        chk({name, "/rst_multi"}, {7'b0, MULTI_ERR}, 8'h00);
        @(negedge CLK40);
        nRESET = 1'b1;
        nTS    = 1'b1;
        ACK    = '0;
        return;
      end
      nTS      = (i == 0) ? 1'b0 : (exp_q[i][0] ? 1'($urandom) : 1'b1);
      SEL      = (i == 0) ? sel : 4'($urandom);
      LINE     = (i == 0) ? line : 1'($urandom);
      BURST_OK = bok;
      noise    = 4'($urandom);
      if (!none) noise[owner] = 1'b0;
      if (ai < ack_cyc.size() && ack_cyc[ai] == i) begin
        noise[owner] = 1'b1;
        ai++;
      end
      ACK = noise;
    end
  endtask

  initial begin
    #17;
    chk("reset/pins", {4'b0, nTA, nTBI, nTEA, BUSY}, 8'h00);
    chk("reset/owner", {6'b0, OWNER}, 8'h00);
    chk("reset/multi", {7'b0, MULTI_ERR}, 8'h00);
    @(negedge CLK40);
    nRESET = 1'b1;

    txn("reg_single",  4'b0001, 1'b0, 4'b0000, 3, 0, 0, 0, 0);
    txn("ram_burst",   4'b0010, 1'b1, 4'b0010, 2, 2, 2, 2, 0);
    txn("chip_nobst",  4'b0100, 1'b1, 4'b0000, 4, 0, 0, 0, 0);
    txn("unclaimed",   4'b0000, 1'b0, 4'b1111, 0, 0, 0, 0, 0);
    txn("collision",   4'b1010, 1'b0, 4'b1111, TO, 0, 0, 0, 0);
    txn("rst_wait",    4'b0001, 1'b0, 4'b0000, 5, 0, 0, 0, 1);
    txn("rst_ack",     4'b0010, 1'b1, 4'b0010, 2, 2, 2, 2, 2);
    txn("after_rst",   4'b1000, 1'b0, 4'b0000, 1, 0, 0, 0, 0);
    txn("beat_tmo",    4'b0010, 1'b1, 4'b0010, 1, 3, TO + 1, 1, 0);

    for (int t = 0; t < 12; t++) begin
      logic [3:0] rs;
      rs = 4'($urandom);
      if (rs == 4'b0000) rs = 4'b0100;
      txn("random", rs, 1'($urandom), 4'($urandom),
          int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
          int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 0);
    end

    @(negedge CLK40);
    nTS = 1'b1;
    ACK = '0;
    chk("final/idle0", {4'b0, nTA, nTBI, nTEA, BUSY}, 8'h00);
    @(negedge CLK40);
    chk("final/idle1", {4'b0, nTA, nTBI, nTEA, BUSY}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
